// File: rtl/overture_pkg.sv
// rtl/overture_pkg.sv - shared types and opcode constants for the Overture sequencer
package overture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        FAULT
    } state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ADDI  = 2'b01;
    localparam logic [1:0] OP_JMP   = 2'b10;
    localparam logic [1:0] OP_SYS   = 2'b11;

    localparam logic [7:0] INSTR_HALT = 8'hC0;

    // Retired count sticks at all-ones rather than wrapping back to zero
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/overture_wait_timer.sv
// rtl/overture_wait_timer.sv - fetch wait counter with clear/enable and expiry flag
module overture_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_MAX - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // High in the final permitted wait cycle: no ack now means the count reaches WAIT_MAX
    assign expired = (count_q == LAST_WAIT);

endmodule

// File: rtl/overture_seq_controller.sv
// rtl/overture_seq_controller.sv - fetch/execute sequencer for the Overture accumulator CPU
module overture_seq_controller #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    output logic [7:0]  pc,
    output logic [7:0]  acc,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    import overture_pkg::*;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  ir_q, ir_d;
    logic [15:0] retired_q, retired_d;
    logic        wait_expired;

    overture_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != FETCH),
        .enable  ((state_q == FETCH) && !imem_ack),
        .expired (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        retired_d = retired_q;

        case (state_q)
            IDLE: begin
                if (start && run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            EXEC: begin
                if (run) begin
                    case (ir_q[7:6])
                        OP_LOADI: begin
                            acc_d     = {2'b00, ir_q[5:0]};
                            pc_d      = pc_q + 8'd1;
                            retired_d = sat_inc16(retired_q);
                            state_d   = FETCH;
                        end
                        OP_ADDI: begin
                            acc_d     = acc_q + {2'b00, ir_q[5:0]};
                            pc_d      = pc_q + 8'd1;
                            retired_d = sat_inc16(retired_q);
                            state_d   = FETCH;
                        end
                        OP_JMP: begin
                            pc_d      = {2'b00, ir_q[5:0]};
                            retired_d = sat_inc16(retired_q);
                            state_d   = FETCH;
                        end
                        default: begin
                            // HALT retires but leaves pc on itself; other SYS encodings are illegal
                            if (ir_q == INSTR_HALT) begin
                                retired_d = sat_inc16(retired_q);
                                state_d   = HALTED;
                            end else begin
                                state_d = FAULT;
                            end
                        end
                    endcase
                end
            end
            HALTED, FAULT: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    acc_d     = 8'd0;
                    retired_d = 16'd0;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            acc_q     <= 8'd0;
            ir_q      <= 8'd0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign halted    = (state_q == HALTED);
    assign fault     = (state_q == FAULT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_overture_seq_controller.sv
// tb/tb_overture_seq_controller.sv - directed vector bench for overture_seq_controller
module tb_overture_seq_controller;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        reset, run, start;
    logic        imem_req, imem_ack, halted, fault;
    logic [7:0]  imem_addr, imem_rdata, pc, acc;
    logic [15:0] retired;

    logic        start_w;
    logic        imem_req_w, imem_ack_w, halted_w, fault_w;
    logic [7:0]  imem_addr_w, imem_rdata_w, pc_w, acc_w;
    logic [15:0] retired_w;

    logic [7:0] rom   [256];
    logic [7:0] rom_w [256];
    logic       ack_en;
    int         ack_delay;
    int         req_cycles;
    int         checks;
    int         fails;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (imem_req && !imem_ack) req_cycles <= req_cycles + 1;
        else                       req_cycles <= 0;
    end

    assign imem_ack     = imem_req && ack_en && (req_cycles >= ack_delay);
    assign imem_rdata   = rom[imem_addr];
    assign imem_ack_w   = imem_req_w;
    assign imem_rdata_w = rom_w[imem_addr_w];

    overture_seq_controller #(.RESET_PC(8'h00), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .run(run), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .acc(acc), .halted(halted), .fault(fault), .retired(retired)
    );

    overture_seq_controller #(.RESET_PC(8'hFF), .WAIT_MAX(WAIT_MAX)) dut_w (
        .clk(clk), .reset(reset), .run(1'b1), .start(start_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .pc(pc_w), .acc(acc_w), .halted(halted_w), .fault(fault_w), .retired(retired_w)
    );

    typedef struct {
        logic        run;
        logic        start;
        logic        req;
        logic [7:0]  pc;
        logic [7:0]  acc;
        logic        halted;
        logic [15:0] ret;
    } vec_t;

    vec_t vt [24];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b1; run = 1'b0; start = 1'b0; start_w = 1'b0;
        ack_en = 1'b1; ack_delay = 0;
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 8'hC1;
            rom_w[i] = 8'hC1;
        end
        rom[0] = 8'h03; rom[1] = 8'h45; rom[2] = 8'h42; rom[3] = 8'hC0;
        rom_w[8'hFF] = 8'h41;
        rom_w[0] = 8'h05; rom_w[1] = 8'h82; rom_w[2] = 8'h00; rom_w[3] = 8'hC0;

        //                run start req pc     acc     halt ret
        vt[0]  = '{1'b1, 1'b1, 1'b1, 8'd0, 8'd0,  1'b0, 16'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0,  1'b0, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 8'd2, 8'd8,  1'b0, 16'd2};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 8'd2, 8'd8,  1'b0, 16'd2};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 8'd3, 8'd10, 1'b0, 16'd3};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd10, 1'b0, 16'd3};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd10, 1'b1, 16'd4};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 8'd3, 8'd10, 1'b1, 16'd4};
        vt[10] = '{1'b1, 1'b1, 1'b1, 8'd0, 8'd0,  1'b0, 16'd0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0,  1'b0, 16'd0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[13] = '{1'b1, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[14] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[15] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[16] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[17] = '{1'b0, 1'b0, 1'b0, 8'd1, 8'd3,  1'b0, 16'd1};
        vt[18] = '{1'b1, 1'b0, 1'b1, 8'd2, 8'd8,  1'b0, 16'd2};
        vt[19] = '{1'b0, 1'b0, 1'b0, 8'd2, 8'd8,  1'b0, 16'd2};
        vt[20] = '{1'b0, 1'b0, 1'b0, 8'd2, 8'd8,  1'b0, 16'd2};
        vt[21] = '{1'b1, 1'b0, 1'b1, 8'd3, 8'd10, 1'b0, 16'd3};
        vt[22] = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd10, 1'b0, 16'd3};
        vt[23] = '{1'b1, 1'b0, 1'b0, 8'd3, 8'd10, 1'b1, 16'd4};

        repeat (2) step();
        reset = 1'b0;

        // Reset state
        check("rst_req", 16'(imem_req), 16'd0);
        check("rst_pc", 16'(pc), 16'h00);
        check("rst_acc", 16'(acc), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_fault", 16'(fault), 16'd0);
        check("rst_retired", retired, 16'd0);
        check("rst_pc_w", 16'(pc_w), 16'hFF);

        // PC wrap from FF and JMP on the RESET_PC=FF instance
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        check("w_fetch_req", 16'(imem_req_w), 16'd1);
        check("w_fetch_addr", 16'(imem_addr_w), 16'hFF);
        repeat (2) step();
        check("w_wrap_pc", 16'(pc_w), 16'h00);
        check("w_wrap_acc", 16'(acc_w), 16'h01);
        repeat (2) step();
        check("w_loadi_acc", 16'(acc_w), 16'h05);
        repeat (2) step();
        check("w_jmp_pc", 16'(pc_w), 16'h02);
        check("w_jmp_acc", 16'(acc_w), 16'h05);
        repeat (2) step();
        check("w_loadi0_pc", 16'(pc_w), 16'h03);
        repeat (2) step();
        check("w_halted", 16'(halted_w), 16'd1);
        check("w_halt_pc", 16'(pc_w), 16'h03);
        check("w_retired", retired_w, 16'd5);

        // Program run, HALT, restart and run=0 stall in EXEC
        for (int i = 0; i < 24; i++) begin
            run   = vt[i].run;
            start = vt[i].start;
            step();
            check($sformatf("vec%0d_req", i), 16'(imem_req), 16'(vt[i].req));
            check($sformatf("vec%0d_pc", i), 16'(pc), 16'(vt[i].pc));
            check($sformatf("vec%0d_acc", i), 16'(acc), 16'(vt[i].acc));
            check($sformatf("vec%0d_halted", i), 16'(halted), 16'(vt[i].halted));
            check($sformatf("vec%0d_retired", i), retired, vt[i].ret);
        end
        start = 1'b0;

        // Fetch timeout with ack withheld
        do_reset();
        ack_en = 1'b0;
        run = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (i > 0) step();
            check($sformatf("to%0d_req", i), 16'(imem_req), 16'd1);
            check($sformatf("to%0d_addr", i), 16'(imem_addr), 16'h00);
            check($sformatf("to%0d_fault", i), 16'(fault), 16'd0);
        end
        step();
        check("to_fault", 16'(fault), 16'd1);
        check("to_fault_req", 16'(imem_req), 16'd0);

        // Ack delayed by 3 cycles completes normally
        ack_en = 1'b1; ack_delay = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("dly_req0", 16'(imem_req), 16'd1);
        check("dly_fault_clr", 16'(fault), 16'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("dly%0d_req", i), 16'(imem_req), 16'd1);
            check($sformatf("dly%0d_addr", i), 16'(imem_addr), 16'h00);
        end
        step();
        check("dly_exec_req", 16'(imem_req), 16'd0);
        check("dly_exec_fault", 16'(fault), 16'd0);
        step();
        check("dly_pc", 16'(pc), 16'h01);
        check("dly_acc", 16'(acc), 16'h03);
        check("dly_retired", retired, 16'd1);
        ack_delay = 0;

        // Illegal opcode faults without retiring, then restart
        do_reset();
        rom[1] = 8'hC1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        check("ill_pre_pc", 16'(pc), 16'h01);
        repeat (2) step();
        check("ill_fault", 16'(fault), 16'd1);
        check("ill_retired", retired, 16'd1);
        check("ill_pc", 16'(pc), 16'h01);
        check("ill_acc", 16'(acc), 16'h03);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_fault", 16'(fault), 16'd0);
        check("rs_req", 16'(imem_req), 16'd1);
        check("rs_pc", 16'(pc), 16'h00);
        check("rs_acc", 16'(acc), 16'h00);
        check("rs_retired", retired, 16'd0);
        rom[1] = 8'h45;

        // Reset during FETCH while ack is high
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        check("mr_pre_req", 16'(imem_req), 16'd1);
        check("mr_pre_ack", 16'(imem_ack), 16'd1);
        check("mr_pre_pc", 16'(pc), 16'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_req", 16'(imem_req), 16'd0);
        check("mr_pc", 16'(pc), 16'h00);
        check("mr_acc", 16'(acc), 16'h00);
        check("mr_retired", retired, 16'd0);
        step();
        check("mr_idle_hold", 16'(imem_req), 16'd0);
        run = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("idle_start_norun", 16'(imem_req), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
